// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Five-stage pipeline hazard controller. Produces stall, flush and
//            bubble controls from load-use, EX redirect and data-memory wait
//            conditions. Also owns a sticky memory-timeout fault and two
//            saturating performance counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [6:0]       ex_op,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             mem_fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FAULT    = 2'b11
  } state_t;

  localparam logic [6:0]       C_OP_LOAD = 7'b0000011;
  localparam logic [15:0]      C_TIMEOUT = TIMEOUT[15:0];
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             load_use;
  logic             freeze;
  logic             redirect_take;

  // Hazard detection: load in EX writing a register the ID instruction reads
  always_comb begin
    load_use = (ex_op == C_OP_LOAD) && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    freeze   = mem_req && !mem_ready;
  end

  // Pipeline controls in priority order: freeze, redirect, load-use
  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idex_stall    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_stall   = 1'b0;
    memwb_bubble  = 1'b0;
    redirect_take = 1'b0;
    if (!clear) begin
      if (state_q == ST_FAULT || freeze) begin
        // Whole front of the pipe holds; a pending redirect re-presents later
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
        // ID instruction is squashed, so any load-use against it is moot
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        redirect_take = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // Next-state logic for the memory-wait/fault machine and the counters
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          if (wait_cnt_d == C_TIMEOUT) begin
            state_d     = ST_FAULT;
            mem_fault_d = 1'b1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
    // Counters are frozen in FAULT because pc_stall there is not a pipeline stall
    if (state_q != ST_FAULT) begin
      if (pc_stall && (stall_cnt_q != C_CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (redirect_take && (flush_cnt_q != C_CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  // State and counter registers with synchronous clear
  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 16'd0;
      mem_fault_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_fault    = mem_fault_q;
  assign state        = state_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl with a behavioural model
//            and directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             clear;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2;
  logic [6:0]       ex_op;
  logic             ex_redirect, mem_req, mem_ready;
  logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic             exmem_stall, memwb_bubble, mem_fault;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Model state: consecutive frozen cycles, fault flag, counter values
  int m_frozen = 0;
  bit m_fault  = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .clear(clear),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_bubble(idex_bubble),
    .exmem_stall(exmem_stall), .memwb_bubble(memwb_bubble),
    .mem_fault(mem_fault), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  function automatic bit f_load_use();
    return (ex_op == 7'b0000011) && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit f_freeze();
    return mem_req && !mem_ready;
  endfunction

  // Expected {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble}
  function automatic logic [6:0] f_ctrl();
    if (clear)                  return 7'b0000000;
    if (m_fault || f_freeze())  return 7'b1101011;
    if (ex_redirect)            return 7'b0010100;
    if (f_load_use())           return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] f_state();
    if (m_fault)       return 2'b11;
    if (m_frozen > 0)  return 2'b01;
    return 2'b00;
  endfunction

  // Model advance at each rising edge
  always @(posedge CLK) begin
    if (clear) begin
      m_frozen = 0; m_fault = 1'b0; m_stall = 0; m_flush = 0;
    end else if (!m_fault) begin
      if (f_ctrl()[6] && m_stall < CMAX) m_stall = m_stall + 1;
      if (!f_freeze() && ex_redirect && m_flush < CMAX) m_flush = m_flush + 1;
      if (f_freeze()) begin
        m_frozen = m_frozen + 1;
        if (m_frozen == TIMEOUT) m_fault = 1'b1;
      end else begin
        m_frozen = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model away from the rising edge
  always @(negedge CLK) begin
    if (check_en) begin
      chk("ctrl", int'({pc_stall, ifid_stall, ifid_flush, idex_stall,
                        idex_bubble, exmem_stall, memwb_bubble}), int'(f_ctrl()));
      chk("state", int'(state), int'(f_state()));
      chk("mem_fault", int'(mem_fault), int'(m_fault));
      chk("stall_cycles", int'(stall_cycles), m_stall);
      chk("flush_count", int'(flush_count), m_flush);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_op = 0; ex_rd = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle_inputs();
    step();
    clear = 1'b0;
  endtask

  task automatic set_load_use();
    ex_op = 7'b0000011; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    clear = 1'b1;
    idle_inputs();
    step();
    step();
    check_en = 1'b1;
    @(negedge CLK);
    chk("reset_state", int'(state), 0);
    chk("reset_stall_cnt", int'(stall_cycles), 0);
    chk("reset_ctrl_forced", int'(pc_stall), 0);
    step();
    clear = 1'b0;

    // Load-use for one cycle, then EX holds the bubble
    set_load_use();
    @(negedge CLK);
    chk("lu_pc_stall", int'(pc_stall), 1);
    chk("lu_ifid_stall", int'(ifid_stall), 1);
    chk("lu_idex_bubble", int'(idex_bubble), 1);
    step();
    idle_inputs();
    @(negedge CLK);
    chk("lu_after_pc_stall", int'(pc_stall), 0);
    chk("lu_stall_cycles", int'(stall_cycles), 1);

    // x0 destination never stalls
    do_clear();
    ex_op = 7'b0000011; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    @(negedge CLK);
    chk("x0_pc_stall", int'(pc_stall), 0);
    step();
    // Matching rs1 that is not actually read never stalls
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
    @(negedge CLK);
    chk("unused_rs1_pc_stall", int'(pc_stall), 0);
    step();

    // Redirect together with load-use: redirect wins
    do_clear();
    set_load_use();
    ex_redirect = 1'b1;
    @(negedge CLK);
    chk("redir_ifid_flush", int'(ifid_flush), 1);
    chk("redir_idex_bubble", int'(idex_bubble), 1);
    chk("redir_pc_stall", int'(pc_stall), 0);
    step();
    idle_inputs();
    @(negedge CLK);
    chk("redir_flush_count", int'(flush_count), 1);

    // Memory wait for 3 cycles with a pending redirect
    do_clear();
    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      chk("mw_pc_stall", int'(pc_stall), 1);
      chk("mw_ifid_flush", int'(ifid_flush), 0);
      chk("mw_state", int'(state), (c == 1) ? 0 : 1);
      step();
    end
    mem_ready = 1'b1;
    @(negedge CLK);
    chk("mw_ready_state", int'(state), 1);
    chk("mw_ready_flush", int'(ifid_flush), 1);
    step();
    idle_inputs();
    @(negedge CLK);
    chk("mw_flush_count", int'(flush_count), 1);
    chk("mw_stall_cycles", int'(stall_cycles), 3);
    chk("mw_back_run", int'(state), 0);

    // Timeout: fault from cycle 5, sticky, cleared by clear
    do_clear();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (c >= 5) begin
        chk("to_state", int'(state), 3);
        chk("to_mem_fault", int'(mem_fault), 1);
      end
      step();
    end
    idle_inputs();
    @(negedge CLK);
    chk("to_sticky_state", int'(state), 3);
    chk("to_stall_cycles", int'(stall_cycles), 4);
    step();
    do_clear();
    @(negedge CLK);
    chk("to_clear_state", int'(state), 0);
    chk("to_clear_fault", int'(mem_fault), 0);
    chk("to_clear_cnt", int'(stall_cycles), 0);

    // Saturation of both counters
    set_load_use();
    repeat (20) step();
    @(negedge CLK);
    chk("sat_stall_cycles", int'(stall_cycles), 15);
    idle_inputs();
    ex_redirect = 1'b1;
    repeat (20) step();
    idle_inputs();
    @(negedge CLK);
    chk("sat_flush_count", int'(flush_count), 15);
    step();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
